ovf_exception_unit: RTL and testbench
=====================================

# ovf_exception_unit

Arithmetic-overflow exception controller for the five-stage MIPS pipeline. It sits directly downstream of the EX-stage overflow detector and consumes its `overflow` flag, qualified by instruction validity and the signed-op enable. On a trap it:
- kills the faulting instruction's writeback,
- flushes the younger instructions,
- captures EPC and Cause,
- redirects fetch to the handler.

It also sequences the return on ERET.

## Interface
Parameters:
- HANDLER_ADDR, 32'h8000_0180, exception vector loaded into PC on trap
- EXC_CODE_OV, 5'd12, Cause.ExcCode value for arithmetic overflow

Ports:
- clk  input  1  pipeline clock, rising-edge
- reset  input  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- overflow  input  1  EX-stage overflow flag from the detector
- ex_valid  input  1  EX stage holds a real (non-bubble) instruction
- ex_ovf_en  input  1  EX instruction is a trapping signed op (add/sub/addi); 0 for addu/subu/addiu
- ex_eret  input  1  EX instruction is ERET
- ex_pc  input  32  PC of the EX-stage instruction
- stall  input  1  pipeline freeze; EX contents held this cycle
- ex_kill  output  1  combinational; suppress EX/MEM writeback of the current EX instruction
- flush  output  1  registered; squash IF/ID/EX contents
- redirect_valid  output  1  registered; load redirect_pc into PC
- redirect_pc  output  32  registered; target PC
- epc  output  32  exception PC register
- cause  output  32  Cause register; ExcCode in bits [6:2], all other bits 0
- in_handler  output  1  high while the handler runs; overflow traps masked
- ovf_count  output  8  saturating count of taken overflow traps

## Operation
Internal signals:
- trap = overflow & ex_valid & ex_ovf_en & ~stall & (state==IDLE)
- ret = ex_eret & ex_valid & ~stall & (state==HANDLER)

Outputs:
- ex_kill = trap, driven combinationally in the same cycle.

FSM states: IDLE, TRAP, HANDLER, RETURN.
- IDLE: on trap, go to TRAP. Same edge: epc<=ex_pc, cause<={25'b0,EXC_CODE_OV,2'b0}, ovf_count += 1 (saturates at 255).
- TRAP: one cycle. flush=1, redirect_valid=1, redirect_pc=HANDLER_ADDR. Next state HANDLER.
- HANDLER: in_handler=1.
  - overflow on a trapping op does not trap and is not counted; ex_kill=0.
  - On ret, go to RETURN.
- RETURN: one cycle. flush=1, redirect_valid=1, redirect_pc=epc. Next state IDLE.
- ERET seen in IDLE: ignored; no redirect, no state change.
- overflow with ex_ovf_en=0, or with ex_valid=0: no effect.
- Simultaneous ret and overflow in HANDLER: ret wins; the overflow is masked.

## Timing
- Reset values: state IDLE, epc 0, cause 0, ovf_count 0, flush 0, redirect_valid 0, redirect_pc 0, in_handler 0.
- ex_kill is combinational, zero latency. It asserts only in the trap cycle N.
- Trap in cycle N:
  - N+1: flush=1, redirect_valid=1, redirect_pc=HANDLER_ADDR, state TRAP.
  - N+2 onward: in_handler=1; flush and redirect_valid return to 0.
- ERET in HANDLER at cycle M:
  - M+1: flush=1, redirect_valid=1, redirect_pc=epc.
  - M+2: IDLE, in_handler=0.
- flush and redirect_valid are single-cycle pulses. They assert regardless of stall, and the pipeline must honour them.
- A stalled cycle never triggers. The held instruction traps once, on its first unstalled cycle.
- epc and cause hold their values until the next trap. ERET does not clear them.
- Asynchronous reset mid-sequence (TRAP/HANDLER/RETURN) forces all reset values immediately. Any pending redirect is dropped.

## Test plan
- Reset, then trap: ex_valid=1, ex_ovf_en=1, overflow=1, ex_pc=32'h0040_0010.
  - Same cycle: ex_kill=1.
  - Next cycle: flush=1, redirect_valid=1, redirect_pc=32'h8000_0180, epc=32'h0040_0010, cause=32'h0000_0030, ovf_count=1.
- Unsigned op: overflow=1 with ex_ovf_en=0 -> ex_kill=0, no flush, epc=0, ovf_count=0.
- Stall hold: overflow with stall=1 for 3 cycles, then stall=0.
  - Exactly one trap, on the first unstalled cycle.
  - ovf_count=1.
- Masking in handler: second overflow at ex_pc=32'h0040_0100 while in_handler=1 -> no ex_kill, epc remains 32'h0040_0010, ovf_count remains 1.
- Return: ERET in HANDLER -> next cycle redirect_pc=32'h0040_0010 with flush=1, then in_handler=0. ERET in IDLE -> no redirect.
- Reset mid-operation: assert reset during the TRAP cycle -> all outputs immediately 0, state IDLE. A new trap after deassertion works normally.

Source files
------------

// File: rtl/ovf_exception_unit.sv
// Arithmetic-overflow exception controller: kills the faulting EX instruction,
// captures EPC/Cause, redirects fetch to the handler, and sequences ERET.
//
// state   | meaning
// IDLE    | normal execution, overflow traps armed
// TRAP    | one-cycle flush + redirect to HANDLER_ADDR
// HANDLER | handler running, overflow traps masked
// RETURN  | one-cycle flush + redirect to epc
module ovf_exception_unit #(
  parameter logic [31:0] HANDLER_ADDR = 32'h8000_0180,
  parameter logic [4:0]  EXC_CODE_OV  = 5'd12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        overflow,
  input  logic        ex_valid,
  input  logic        ex_ovf_en,
  input  logic        ex_eret,
  input  logic [31:0] ex_pc,
  input  logic        stall,
  output logic        ex_kill,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] epc,
  output logic [31:0] cause,
  output logic        in_handler,
  output logic [7:0]  ovf_count
);

  typedef enum logic [1:0] {IDLE, TRAP, HANDLER, RETURN} state_t;

  state_t      state, state_nxt;
  logic        trap, ret;
  logic        pulse_nxt;
  logic [31:0] rpc_nxt;

  assign trap       = overflow & ex_valid & ex_ovf_en & ~stall & (state == IDLE);
  assign ret        = ex_eret & ex_valid & ~stall & (state == HANDLER);
  assign ex_kill    = trap;
  assign in_handler = (state == HANDLER);

  always_comb begin
    state_nxt = state;
    pulse_nxt = 1'b0;
    rpc_nxt   = redirect_pc;
    case (state)
      IDLE:    if (trap) state_nxt = TRAP;
      TRAP:    state_nxt = HANDLER;
      HANDLER: if (ret) state_nxt = RETURN;
      RETURN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // flush/redirect are registered copies of entering TRAP or RETURN
    if (state_nxt == TRAP) begin
      pulse_nxt = 1'b1;
      rpc_nxt   = HANDLER_ADDR;
    end else if (state_nxt == RETURN) begin
      pulse_nxt = 1'b1;
      rpc_nxt   = epc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
      epc            <= 32'h0;
      cause          <= 32'h0;
      ovf_count      <= 8'h0;
    end else begin
      state          <= state_nxt;
      flush          <= pulse_nxt;
      redirect_valid <= pulse_nxt;
      redirect_pc    <= rpc_nxt;
      if (trap) begin
        epc   <= ex_pc;
        cause <= {25'b0, EXC_CODE_OV, 2'b00};
        if (ovf_count != 8'hFF) ovf_count <= ovf_count + 8'h1;
      end
    end
  end

endmodule

// File: tb/tb_ovf_exception_unit.sv
// Directed bench for ovf_exception_unit with an event-level reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_ovf_exception_unit;

  localparam logic [31:0] HADDR = 32'h8000_0180;
  localparam logic [31:0] CAUSE_OV = 32'h0000_0030;

  logic        clk = 1'b0;
  logic        reset;
  logic        overflow, ex_valid, ex_ovf_en, ex_eret, stall;
  logic [31:0] ex_pc;
  logic        ex_kill, flush, redirect_valid, in_handler;
  logic [31:0] redirect_pc, epc, cause;
  logic [7:0]  ovf_count;

  int n_vec = 0;
  int n_err = 0;

  ovf_exception_unit dut (
    .clk(clk), .reset(reset), .overflow(overflow), .ex_valid(ex_valid),
    .ex_ovf_en(ex_ovf_en), .ex_eret(ex_eret), .ex_pc(ex_pc), .stall(stall),
    .ex_kill(ex_kill), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .epc(epc), .cause(cause),
    .in_handler(in_handler), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  // Reference model: "handler entered" flag plus a pending one-cycle redirect pulse.
  bit          m_handler, m_pulse;
  logic [31:0] m_target, m_epc, m_cause;
  int          m_count;

  function automatic bit m_trap();
    return overflow & ex_valid & ex_ovf_en & ~stall & ~m_handler & ~m_pulse;
  endfunction

  function automatic bit m_ret();
    return ex_eret & ex_valid & ~stall & m_handler & ~m_pulse;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_handler = 0; m_pulse = 0; m_target = 0;
      m_epc = 0; m_cause = 0; m_count = 0;
    end else begin
      bit t, r;
      t = m_trap();
      r = m_ret();
      m_pulse = 0;
      if (t) begin
        m_pulse = 1; m_target = HADDR; m_handler = 1;
        m_epc = ex_pc; m_cause = 32'd12 * 4;
        if (m_count < 255) m_count = m_count + 1;
      end else if (r) begin
        m_pulse = 1; m_target = m_epc; m_handler = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m.ex_kill", 32'(ex_kill), 32'(m_trap()));
    chk("m.flush", 32'(flush), 32'(m_pulse));
    chk("m.redirect_valid", 32'(redirect_valid), 32'(m_pulse));
    if (m_pulse) chk("m.redirect_pc", redirect_pc, m_target);
    chk("m.epc", epc, m_epc);
    chk("m.cause", cause, m_cause);
    chk("m.in_handler", 32'(in_handler), 32'(m_handler & ~m_pulse));
    chk("m.ovf_count", 32'(ovf_count), 32'(m_count));
  end

  task automatic drv(input logic ov, input logic v, input logic en,
                     input logic er, input logic st, input logic [31:0] pc);
    overflow = ov; ex_valid = v; ex_ovf_en = en; ex_eret = er; stall = st; ex_pc = pc;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; idle(); tick(); tick(); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; idle();
    tick(); tick();
    chk("rst.flush", 32'(flush), 0);
    chk("rst.redirect_valid", 32'(redirect_valid), 0);
    chk("rst.redirect_pc", redirect_pc, 0);
    chk("rst.epc", epc, 0);
    chk("rst.cause", cause, 0);
    chk("rst.in_handler", 32'(in_handler), 0);
    chk("rst.ovf_count", 32'(ovf_count), 0);
    reset = 1'b0;

    // unsigned op and bubble: no effect
    drv(1, 1, 0, 0, 0, 32'h0040_0004); #2;
    chk("unsigned.ex_kill", 32'(ex_kill), 0);
    tick();
    chk("unsigned.flush", 32'(flush), 0);
    chk("unsigned.epc", epc, 0);
    chk("unsigned.count", 32'(ovf_count), 0);
    drv(1, 0, 1, 0, 0, 32'h0040_0008); #2;
    chk("bubble.ex_kill", 32'(ex_kill), 0);
    tick();

    // ERET in IDLE is ignored
    drv(0, 1, 0, 1, 0, 32'h0040_000C); tick();
    chk("eret_idle.redirect_valid", 32'(redirect_valid), 0);
    chk("eret_idle.flush", 32'(flush), 0);

    // trap
    drv(1, 1, 1, 0, 0, 32'h0040_0010); #2;
    chk("trap.ex_kill", 32'(ex_kill), 1);
    tick(); idle();
    chk("trap.flush", 32'(flush), 1);
    chk("trap.redirect_valid", 32'(redirect_valid), 1);
    chk("trap.redirect_pc", redirect_pc, HADDR);
    chk("trap.epc", epc, 32'h0040_0010);
    chk("trap.cause", cause, CAUSE_OV);
    chk("trap.count", 32'(ovf_count), 1);
    tick();
    chk("handler.in_handler", 32'(in_handler), 1);
    chk("handler.flush", 32'(flush), 0);

    // masked overflow in handler
    drv(1, 1, 1, 0, 0, 32'h0040_0100); #2;
    chk("mask.ex_kill", 32'(ex_kill), 0);
    tick();
    chk("mask.epc", epc, 32'h0040_0010);
    chk("mask.count", 32'(ovf_count), 1);

    // ERET together with overflow: return wins
    drv(1, 1, 1, 1, 0, 32'h0040_0104); #2;
    chk("ret.ex_kill", 32'(ex_kill), 0);
    tick(); idle();
    chk("ret.flush", 32'(flush), 1);
    chk("ret.redirect_valid", 32'(redirect_valid), 1);
    chk("ret.redirect_pc", redirect_pc, 32'h0040_0010);
    tick();
    chk("ret.in_handler", 32'(in_handler), 0);
    chk("ret.epc_held", epc, 32'h0040_0010);
    chk("ret.count", 32'(ovf_count), 1);

    // stall hold: one trap on the first unstalled cycle
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 1, 0, 1, 32'h0040_0020); #2;
      chk("stall.ex_kill", 32'(ex_kill), 0);
      tick();
      chk("stall.flush", 32'(flush), 0);
    end
    drv(1, 1, 1, 0, 0, 32'h0040_0020); #2;
    chk("unstall.ex_kill", 32'(ex_kill), 1);
    tick();
    chk("unstall.flush", 32'(flush), 1);
    chk("unstall.count", 32'(ovf_count), 1);
    chk("unstall.epc", epc, 32'h0040_0020);
    tick();
    chk("unstall.count_once", 32'(ovf_count), 1);
    // stalled ERET does not return
    drv(0, 1, 0, 1, 1, 32'h0040_0200); tick();
    chk("stall_eret.redirect_valid", 32'(redirect_valid), 0);
    chk("stall_eret.in_handler", 32'(in_handler), 1);
    drv(0, 1, 0, 1, 0, 32'h0040_0200); tick(); idle();
    chk("eret.redirect_pc", redirect_pc, 32'h0040_0020);
    tick();

    // reset during TRAP
    drv(1, 1, 1, 0, 0, 32'h0040_0030); tick(); idle();
    chk("pre_rst.flush", 32'(flush), 1);
    reset = 1'b1; #1;
    chk("midrst.flush", 32'(flush), 0);
    chk("midrst.redirect_valid", 32'(redirect_valid), 0);
    chk("midrst.redirect_pc", redirect_pc, 0);
    chk("midrst.epc", epc, 0);
    chk("midrst.count", 32'(ovf_count), 0);
    tick(); reset = 1'b0; tick();
    chk("postrst.in_handler", 32'(in_handler), 0);
    chk("postrst.flush", 32'(flush), 0);
    drv(1, 1, 1, 0, 0, 32'h0040_0040); #2;
    chk("retrap.ex_kill", 32'(ex_kill), 1);
    tick(); idle();
    chk("retrap.redirect_pc", redirect_pc, HADDR);
    chk("retrap.epc", epc, 32'h0040_0040);
    chk("retrap.count", 32'(ovf_count), 1);
    tick();

    // saturation of ovf_count
    do_reset();
    for (int i = 0; i < 260; i++) begin
      drv(1, 1, 1, 0, 0, 32'h0041_0000 + 32'(i * 4)); tick(); idle(); tick();
      drv(0, 1, 0, 1, 0, 32'h0);  tick(); idle(); tick();
    end
    chk("sat.count", 32'(ovf_count), 255);
    chk("sat.epc", epc, 32'h0041_0000 + 32'(259 * 4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
